pd_stream_fifo: RTL
===================

Name: pd_stream_fifo

Overview:
- Parametrised elastic buffer for the posit-decoded (pd) stream.
- Carries scale, fraction and NaR/sign/zero/guard/round/sticky, plus sow/eow framing, between a pd producer and a pd consumer.
- Handshake on both sides is rts/rtr; adds DEPTH-word buffering, an optional store-and-forward mode, and frame-protocol checking.
- Sits between posit decoder and arithmetic core, or between pipeline stages that stall independently.

Parameters:
- POSIT_WIDTH, 32, posit width; selects scale_width (SW) and fraction_width (FW) via the package functions.
- POSIT_ES, 2, exponent size.
- PD_TYPE, NORMAL, pd flavour passed to get_scale_width/get_fraction_width.
- DEPTH, 4, number of entries; power of two, ≥2.
- MODE, CUT_THROUGH, CUT_THROUGH or STORE_FORWARD.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- s_pd  interface  pd_control_if.slave  upstream stream (rts, rtr, sow, eow, data).
- m_pd  interface  pd_control_if.master  downstream stream.
- level  output  $clog2(DEPTH)+1  current occupancy.
- frames  output  $clog2(DEPTH)+1  number of eow words currently stored.
- frame_err  output  1  one-cycle pulse on a framing violation at the input.

Behaviour:
- Beat transfer: a side transfers one beat iff rts && rtr on a rising clk.
- Stored word: {sow, eow, NaR, sign, zero, guard, round, sticky, scale, fraction}; width SW+FW+8.
- Reset (rst=1 at clk edge):
  - level=0, frames=0, pointers=0, frame_err=0, framing FSM=IDLE.
  - s_pd.rtr=0 and m_pd.rts=0 while rst is high.
  - m_pd data fields are don't-care whenever m_pd.rts=0.
  - Reset mid-operation discards all contents; no partial beat survives.
- s_pd.rtr: registered; equals (level<DEPTH) after reset, updated the same cycle level changes. Must not depend combinationally on m_pd.rtr.
- Push: when s_pd.rts && s_pd.rtr, write at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
- Pop: when m_pd.rts && m_pd.rtr, rd_ptr+1 (wraps mod DEPTH).
- Data output: m_pd data = entry at rd_ptr (first-word fall-through).
- Latency: a word pushed at edge N is visible with m_pd.rts=1 after edge N (one cycle), in CUT_THROUGH mode.
- Simultaneous push and pop: level unchanged; allowed at any level except empty (pop impossible) and full (push impossible since rtr=0).
- Full: level=DEPTH → s_pd.rtr=0 the next cycle.
- Empty: m_pd.rts=0.
- frames: +1 on push with eow=1, −1 on pop with eow=1; both in the same cycle → unchanged.
- m_pd.rts:
  - CUT_THROUGH: level≠0.
  - STORE_FORWARD: level≠0 && (frames≠0 || level==DEPTH). The full override prevents deadlock on frames longer than DEPTH.
- Framing FSM (on accepted input beats only), states IDLE, IN_FRAME:
  - IDLE, sow&&eow → IDLE (single-word frame).
  - IDLE, sow&&!eow → IN_FRAME.
  - IDLE, !sow → frame_err pulse, state unchanged (data still stored).
  - IN_FRAME, sow → frame_err pulse, state IN_FRAME (new frame restarts); with eow also → IDLE.
  - IN_FRAME, !sow&&eow → IDLE.
  - IN_FRAME, neither → IN_FRAME.
- frame_err is registered and asserted the cycle after the offending beat. Errors never block or drop data.

Decomposition:
- posit_defines: add typedef enum fifo_mode_t {CUT_THROUGH, STORE_FORWARD}, and function get_pd_word_width(POSIT_WIDTH, POSIT_ES, PD_TYPE) = scale_width+fraction_width+8. Existing pd_type, get_scale_width and get_fraction_width are reused.
- One sub-module, pd_fifo_ram: DEPTH×W storage, synchronous write, asynchronous read, no reset on contents.
- Framing FSM and counters stay in pd_stream_fifo.

Test Plan:
- Reset then idle, POSIT_WIDTH=32, ES=2, DEPTH=4 → level=0, m_pd.rts=0, s_pd.rtr=1 from first cycle after rst drops.
- CUT_THROUGH, push 4 single-word frames (scale=1..4, sow=eow=1) with m_pd.rtr=0 → level=4, frames=4, s_pd.rtr=0; release rtr → outputs scale 1,2,3,4 in order, one per cycle, then rts=0.
- Continuous push/pop with both rts/rtr=1 for 20 beats → level stays 1, output sequence equals input, s_pd.rtr never drops; pointers wrap 5 times without corruption.
- STORE_FORWARD, DEPTH=4, push 3-word frame (sow, -, eow) one beat per cycle → m_pd.rts=0 until the cycle after the eow push, then 3 pops; 6-word frame → rts asserts when level=4, no deadlock.
- Framing errors: beat with sow=0 while IDLE → frame_err=1 for exactly one cycle, word still emerges; sow twice without eow → one frame_err pulse.
- Assert rst with level=3 mid-frame → next cycle level=0, frames=0, m_pd.rts=0, FSM IDLE; new frame accepted normally.

Source files
------------

// File: rtl/pd_stream_fifo_pkg.sv
// Shared types and width helpers for the posit-decoded (pd) stream.
package pd_stream_fifo_pkg;

    typedef enum logic {NORMAL, EXTENDED} pd_type;

    typedef enum logic {CUT_THROUGH, STORE_FORWARD} fifo_mode_t;

    typedef enum logic {IDLE, IN_FRAME} frm_state_t;

    // Signed scale covering regime and exponent; the extended flavour keeps one spare bit.
    function automatic int unsigned get_scale_width(int unsigned posit_width,
                                                    int unsigned posit_es,
                                                    pd_type      t);
        return 32'($clog2(posit_width)) + posit_es + ((t == EXTENDED) ? 32'd2 : 32'd1);
    endfunction

    // Fraction bits left after sign, shortest regime and exponent.
    function automatic int unsigned get_fraction_width(int unsigned posit_width,
                                                       int unsigned posit_es,
                                                       pd_type      t);
        return (t == EXTENDED) ? (posit_width - posit_es - 32'd1)
                               : (posit_width - posit_es - 32'd3);
    endfunction

    // Stored word: sow, eow, six flag bits, scale and fraction.
    function automatic int unsigned get_pd_word_width(int unsigned posit_width,
                                                      int unsigned posit_es,
                                                      pd_type      t);
        return get_scale_width(posit_width, posit_es, t)
             + get_fraction_width(posit_width, posit_es, t) + 32'd8;
    endfunction

endpackage

// File: rtl/pd_control_if.sv
// rts/rtr handshake carrying one pd beat with sow/eow framing.
interface pd_control_if
    import pd_stream_fifo_pkg::*;
#(
    parameter int unsigned POSIT_WIDTH = 32,
    parameter int unsigned POSIT_ES    = 2,
    parameter pd_type      PD_TYPE     = NORMAL
);
    localparam int unsigned SW = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
    localparam int unsigned FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

    logic          rts;
    logic          rtr;
    logic          sow;
    logic          eow;
    logic          nar;
    logic          sign;
    logic          zero;
    logic          guard;
    logic          round;
    logic          sticky;
    logic [SW-1:0] scale;
    logic [FW-1:0] fraction;

    modport master (output rts, sow, eow, nar, sign, zero, guard, round, sticky, scale, fraction,
                    input  rtr);
    modport slave  (input  rts, sow, eow, nar, sign, zero, guard, round, sticky, scale, fraction,
                    output rtr);
endinterface

// File: rtl/pd_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, contents not reset.
module pd_fifo_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata_c
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];
endmodule

// File: rtl/pd_stream_fifo.sv
// Elastic buffer for the pd stream with optional store-and-forward and frame checking.
module pd_stream_fifo
    import pd_stream_fifo_pkg::*;
#(
    parameter int unsigned POSIT_WIDTH = 32,
    parameter int unsigned POSIT_ES    = 2,
    parameter pd_type      PD_TYPE     = NORMAL,
    parameter int unsigned DEPTH       = 4,
    parameter fifo_mode_t  MODE        = CUT_THROUGH
) (
    input  logic                   clk,
    input  logic                   rst,
    pd_control_if.slave            s_pd,
    pd_control_if.master           m_pd,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] frames,
    output logic                   frame_err
);
    localparam int unsigned AW = unsigned'($clog2(DEPTH));
    localparam int unsigned LW = AW + 1;
    localparam int unsigned W  = get_pd_word_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rtr_q, rts_q, rts_d;
    logic [LW-1:0] level_d, frames_d;
    logic          push, pop;
    logic [W-1:0]  wdata, rdata_c;
    frm_state_t    state, state_nx;
    logic          err_c;

    assign push     = s_pd.rts && rtr_q;
    assign pop      = rts_q && m_pd.rtr;
    assign s_pd.rtr = rtr_q;
    assign m_pd.rts = rts_q;

    assign wdata = {s_pd.sow, s_pd.eow, s_pd.nar, s_pd.sign, s_pd.zero,
                    s_pd.guard, s_pd.round, s_pd.sticky, s_pd.scale, s_pd.fraction};
    assign {m_pd.sow, m_pd.eow, m_pd.nar, m_pd.sign, m_pd.zero,
            m_pd.guard, m_pd.round, m_pd.sticky, m_pd.scale, m_pd.fraction} = rdata_c;

    pd_fifo_ram #(.DEPTH(DEPTH), .WIDTH(W)) u_ram (
        .clk     (clk),
        .we      (push),
        .waddr   (wr_ptr),
        .wdata   (wdata),
        .raddr   (rd_ptr),
        .rdata_c (rdata_c)
    );

    // Next occupancy, stored-frame count and output-valid; store-forward releases on a full buffer to avoid deadlock.
    always_comb begin
        level_d  = level + LW'(push) - LW'(pop);
        frames_d = frames + LW'(push && s_pd.eow) - LW'(pop && rdata_c[W-2]);
        if (MODE == STORE_FORWARD) begin
            rts_d = (level_d != '0) && ((frames_d != '0) || (level_d == LW'(DEPTH)));
        end else begin
            rts_d = (level_d != '0);
        end
    end

    // Pointers, counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            frames <= '0;
            rtr_q  <= 1'b0;
            rts_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level  <= level_d;
            frames <= frames_d;
            rtr_q  <= (level_d < LW'(DEPTH));
            rts_q  <= rts_d;
        end
    end

    // Framing state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Framing next state on accepted input beats; a stray sow restarts the frame.
    always_comb begin
        state_nx = state;
        if (push) begin
            case (state)
                IDLE:     if (s_pd.sow && !s_pd.eow) state_nx = IN_FRAME;
                IN_FRAME: if (s_pd.eow)              state_nx = IDLE;
                default:                             state_nx = IDLE;
            endcase
        end
    end

    // Framing violation: missing sow while idle, or sow inside a frame.
    always_comb begin
        err_c = 1'b0;
        if (push) begin
            case (state)
                IDLE:     err_c = !s_pd.sow;
                IN_FRAME: err_c = s_pd.sow;
                default:  err_c = 1'b0;
            endcase
        end
    end

    // One-cycle error pulse after the offending beat.
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= err_c;
    end
endmodule
